bitstream_packer: RTL and testbench

BITSTREAM_PACKER -- requirements
Module: bitstream_packer

---
 rtl/bitstream_packer.sv | 124 ++++++++++++
 tb/tb_bitstream_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_packer.sv
// Packs variable-length codes (0..16 bits, MSB-first) into 32-bit words for the
// encoded-word RAM. A final partial word is padded with 1s, then bitti_o pulses once.
module bitstream_packer #(
    parameter int MAX_KELIME = 2406
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] kod_i,
    input  logic [4:0]  uzunluk_i,
    input  logic        son_i,
    output logic        hazir_o,
    output logic [31:0] kelime_o,
    output logic        kelime_gecerli_o,
    input  logic        kelime_hazir_i,
    output logic [12:0] adres_o,
    output logic        bitti_o,
    output logic        tasma_o
);

    typedef enum logic [1:0] {PACK, FLUSH, DONE} state_e;

    state_e      state_q;
    logic [63:0] acc_q, acc_d;
    logic [6:0]  sayac_q, sayac_d;
    logic [31:0] kelime_q, word_d;
    logic        vld_q;
    logic [12:0] adres_q;
    logic        bitti_q;
    logic        tasma_q;

    logic [4:0]  len;
    logic [16:0] mask17;
    logic [15:0] code16;
    logic        xfer, can_load, load_full, load_pad, handoff;
    logic [63:0] base_acc, placed;
    logic [6:0]  base_cnt;

    assign hazir_o          = (state_q == PACK) && (sayac_q <= 7'd48);
    assign kelime_o         = kelime_q;
    assign kelime_gecerli_o = vld_q;
    assign adres_o          = adres_q;
    assign bitti_o          = bitti_q;
    assign tasma_o          = tasma_q;

    always_comb begin
        len       = (uzunluk_i > 5'd16) ? 5'd16 : uzunluk_i;
        mask17    = (17'd1 << len) - 17'd1;
        code16    = kod_i & mask17[15:0];
        xfer      = en_i && hazir_o;
        can_load  = !vld_q || kelime_hazir_i;
        handoff   = vld_q && kelime_hazir_i;
        load_full = (sayac_q >= 7'd32) && can_load;
        load_pad  = (state_q == FLUSH) && (sayac_q != 7'd0) && (sayac_q < 7'd32) && can_load;

        // Held bits sit at the top of the accumulator; a code lands right below them,
        // after the outgoing word (if any) has been shifted away.
        base_acc = load_full ? {acc_q[31:0], 32'b0} : acc_q;
        base_cnt = load_full ? (sayac_q - 7'd32) : sayac_q;
        placed   = ({code16, 48'b0} << (5'd16 - len)) >> base_cnt;

        acc_d   = base_acc | (xfer ? placed : 64'b0);
        sayac_d = base_cnt + (xfer ? {2'b0, len} : 7'd0);
        word_d  = acc_q[63:32];
        if (load_pad) begin
            word_d  = acc_q[63:32] | (32'hFFFF_FFFF >> sayac_q);
            acc_d   = 64'b0;
            sayac_d = 7'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PACK;
            acc_q    <= 64'b0;
            sayac_q  <= 7'd0;
            kelime_q <= 32'b0;
            vld_q    <= 1'b0;
            adres_q  <= 13'd0;
            bitti_q  <= 1'b0;
            tasma_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sayac_q <= sayac_d;

            if (load_full || load_pad) begin
                kelime_q <= word_d;
                vld_q    <= 1'b1;
            end else if (handoff) begin
                vld_q <= 1'b0;
            end

            if (handoff) begin
                if (adres_q == 13'(MAX_KELIME - 1)) begin
                    adres_q <= 13'd0;
                    tasma_q <= 1'b1;
                end else begin
                    adres_q <= adres_q + 13'd1;
                end
            end

            case (state_q)
                PACK: begin
                    bitti_q <= 1'b0;
                    if (xfer && son_i) state_q <= FLUSH;
                end
                FLUSH: begin
                    // Only finish once the last word has actually left.
                    if (sayac_q == 7'd0 && !vld_q) begin
                        state_q <= DONE;
                        bitti_q <= 1'b1;
                        adres_q <= 13'd0;
                    end
                end
                DONE: begin
                    bitti_q <= 1'b0;
                    state_q <= PACK;
                end
                default: state_q <= PACK;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_packer.sv
// Bench for bitstream_packer: bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bitstream_packer;

    localparam int MAXK = 8;

    logic        clk, rst_n, en, son, khz;
    logic [15:0] kod;
    logic [4:0]  len;
    logic        hazir_o, vld_o, bitti_o, tasma_o;
    logic [31:0] kelime_o;
    logic [12:0] adres_o;

    bitstream_packer #(.MAX_KELIME(MAXK)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .kod_i(kod), .uzunluk_i(len),
        .son_i(son), .hazir_o(hazir_o), .kelime_o(kelime_o),
        .kelime_gecerli_o(vld_o), .kelime_hazir_i(khz), .adres_o(adres_o),
        .bitti_o(bitti_o), .tasma_o(tasma_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int hand_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: a plain bit stream; words are cut 32 bits at a time.
    bit          bq[$];
    logic [31:0] wq[$];
    bit          flushing = 0, exp_tasma = 0, hold_prev = 0;
    int          exp_addr = 0;
    logic [31:0] prev_k;
    logic [12:0] prev_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            bq.delete(); wq.delete();
            flushing = 0; exp_tasma = 0; hold_prev = 0; exp_addr = 0;
        end else begin
            bit was_fl;
            was_fl = flushing;
            chk("tasma", tasma_o, exp_tasma);
            if (hold_prev) begin
                chk("hold_vld", vld_o, 1);
                chk("hold_kelime", kelime_o, prev_k);
                chk("hold_adres", adres_o, prev_a);
            end
            if (bitti_o) begin
                chk("bitti_expected", flushing, 1);
                chk("flush_words_left", wq.size(), 0);
                chk("bitti_adres", adres_o, 0);
                flushing = 0;
                exp_addr = 0;
            end
            if (was_fl || bitti_o) chk("hazir_in_flush", hazir_o, 0);
            if (vld_o && khz) begin
                if (wq.size() == 0) chk("unexpected_word", kelime_o, 64'hDEAD_0000_0000);
                else begin
                    logic [31:0] w;
                    w = wq.pop_front();
                    chk("kelime", kelime_o, w);
                    chk("adres", adres_o, exp_addr);
                end
                hand_cnt++;
                if (exp_addr == MAXK - 1) begin exp_addr = 0; exp_tasma = 1; end
                else exp_addr++;
            end
            if (en && hazir_o) begin
                int n;
                n = (len > 16) ? 16 : int'(len);
                for (int i = n - 1; i >= 0; i--) bq.push_back(kod[i]);
                if (son) begin
                    while (bq.size() % 32 != 0) bq.push_back(1'b1);
                    flushing = 1;
                end
                while (bq.size() >= 32) begin
                    logic [31:0] w;
                    w = '0;
                    for (int i = 0; i < 32; i++) w = {w[30:0], bq.pop_front()};
                    wq.push_back(w);
                end
            end
            hold_prev = vld_o && !khz;
            prev_k = kelime_o;
            prev_a = adres_o;
        end
    end

    task automatic idle();
        en = 0; son = 0;
    endtask

    task automatic send(input logic [15:0] k, input logic [4:0] l, input logic s);
        bit ok;
        en = 1; kod = k; len = l; son = s; ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = hazir_o;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_word(input logic [31:0] ek, input logic [12:0] ea, input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (vld_o && khz) begin
                found = 1;
                chk({nm, "_kelime"}, kelime_o, ek);
                chk({nm, "_adres"}, adres_o, ea);
            end
            @(posedge clk); #1;
        end
        if (!found) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_bitti(input string nm);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = bitti_o;
            @(posedge clk); #1;
        end
        chk({nm, "_bitti"}, found, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0;
        rst_n = 0; en = 0; son = 0; khz = 0; kod = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        @(negedge clk);
        chk("rst_hazir", hazir_o, 1);
        chk("rst_vld", vld_o, 0);
        chk("rst_kelime", kelime_o, 0);
        chk("rst_adres", adres_o, 0);
        chk("rst_bitti", bitti_o, 0);
        chk("rst_tasma", tasma_o, 0);
        @(posedge clk); #1;

        // Four bytes -> one word, valid the cycle after the fourth transfer
        khz = 1;
        send(16'hAA, 8, 0); send(16'hBB, 8, 0); send(16'hCC, 8, 0); send(16'hDD, 8, 0);
        idle();
        @(negedge clk);
        chk("lat_not_yet", vld_o, 0);
        @(negedge clk);
        chk("lat_vld", vld_o, 1);
        chk("w0_kelime", kelime_o, 32'hAABBCCDD);
        chk("w0_adres", adres_o, 0);
        @(posedge clk); #1;
        send(16'h11, 8, 0); send(16'h22, 8, 0); send(16'h33, 8, 0); send(16'h44, 8, 0);
        idle();
        wait_word(32'h11223344, 1, "w1");
        send(0, 0, 1); idle();
        wait_bitti("len0_son");

        // Short final code is padded with ones
        send(16'h5, 3, 1); idle();
        wait_word(32'hBFFFFFFF, 0, "pad");
        wait_bitti("pad");
        @(negedge clk);
        chk("after_bitti_adres", adres_o, 0);
        chk("bitti_one_cycle", bitti_o, 0);
        @(posedge clk); #1;

        // Backpressure: word held, hazir drops once 64 bits are held
        khz = 0;
        send(16'h1234, 16, 0); send(16'h5678, 16, 0); send(16'h9ABC, 16, 0);
        send(16'hDEF0, 16, 0); send(16'h1111, 16, 0); send(16'h2222, 16, 0);
        en = 1; kod = 16'h3333; len = 16;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hazir_low", hazir_o, 0);
            chk("bp_kelime", kelime_o, 32'h12345678);
            chk("bp_vld", vld_o, 1);
            @(posedge clk); #1;
        end
        khz = 1;
        send(16'h3333, 16, 1); idle();
        wait_bitti("bp");

        // Exact 32 bits with son: one word, no padding word
        h0 = hand_cnt;
        send(16'hCAFE, 16, 0); send(16'hBEEF, 16, 1); idle();
        wait_word(32'hCAFEBEEF, 0, "exact");
        wait_bitti("exact");
        chk("exact_one_word", hand_cnt - h0, 1);

        // Asynchronous reset mid-stream with a pending word and 20 held bits
        khz = 0;
        send(16'hAA, 8, 0); send(16'hBB, 8, 0); send(16'hCC, 8, 0); send(16'hDD, 8, 0);
        send(16'h1234, 16, 0); send(16'h5, 4, 0); idle();
        chk("pre_rst_vld", vld_o, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_vld", vld_o, 0);
        chk("arst_kelime", kelime_o, 0);
        chk("arst_adres", adres_o, 0);
        chk("arst_hazir", hazir_o, 1);
        @(posedge clk); #1;
        rst_n = 1; khz = 1;
        send(16'hAA, 8, 0); send(16'hBB, 8, 0); send(16'hCC, 8, 0); send(16'hDD, 8, 0);
        idle();
        wait_word(32'hAABBCCDD, 0, "post_rst");
        send(0, 0, 1); idle();
        wait_bitti("post_rst");

        // Randomized traffic, including out-of-range lengths and address wrap
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom % 4) != 0;
            kod = 16'($urandom);
            len = 5'($urandom_range(0, 20));
            son = ($urandom % 150) == 0;
            khz = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        idle(); khz = 1;
        send(16'h0, 0, 1); idle();
        wait_bitti("rand_end");
        chk("tasma_sticky", tasma_o, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
